// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg: shared width defaults, NOP encoding and fetch-entry type for the fetch stage.
package if_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_CMD = '0;
  typedef struct packed {
    logic [XLEN-1:0] cmd;
    logic [XLEN-1:0] pc_plus4;
  } fetch_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/if_fetch_queue_fifo.sv
// sync_fifo: circular buffer with push/pop/clear, occupancy output and a registered read pointer.
module sync_fifo #(
  parameter int W = 64,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 clr,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [$clog2(D):0]   occ
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (push && !clr) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wp <= '0;
      rp <= '0;
      occ <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && occ == (AW+1)'(D)));
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: latency-tolerant fetch stage; issues imem requests, queues responses, feeds IF/ID.
module if_fetch_queue import if_pkg::*; #(
  parameter int XLEN = if_pkg::XLEN,
  parameter int QDEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stallD,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] cmdD,
  output logic [XLEN-1:0] PCPlusFourD,
  output logic            validD
);
  localparam int CW = cnt_w(QDEPTH);
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);
  logic [XLEN-1:0] pc, rpc;
  logic [CW-1:0] occ, infl, drop, live;
  logic [2*XLEN-1:0] head;
  logic acc, push, pop;
  assign live = infl - drop;
  // Reserve queue space for every live request so a response can always be pushed.
  assign imem_req = rst_n && !PCSrcD && ({1'b0, occ} + {1'b0, live} < QD) && (infl < QD[CW-1:0]);
  assign imem_addr = pc;
  assign acc = imem_req && imem_gnt;
  assign push = imem_rvalid && drop == '0 && !PCSrcD;
  assign pop = !stallD && !PCSrcD && occ != '0;
  sync_fifo #(.W(2*XLEN), .D(QDEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(PCSrcD),
    .din({imem_rdata, rpc + XLEN'(4)}), .dout(head), .occ(occ)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      rpc <= RESET_PC;
      infl <= '0;
      drop <= '0;
      cmdD <= '0;
      PCPlusFourD <= '0;
      validD <= 1'b0;
    end else begin
      infl <= infl + CW'(acc) - CW'(imem_rvalid);
      if (PCSrcD) begin
        pc <= PCBranchD;
        rpc <= PCBranchD;
        drop <= infl - CW'(imem_rvalid);
        cmdD <= XLEN'(NOP_CMD);
        PCPlusFourD <= '0;
        validD <= 1'b0;
      end else begin
        if (acc) pc <= pc + XLEN'(4);
        if (push) rpc <= rpc + XLEN'(4);
        if (imem_rvalid && drop != '0) drop <= drop - CW'(1);
        if (!stallD) begin
          cmdD <= pop ? head[2*XLEN-1:XLEN] : XLEN'(NOP_CMD);
          PCPlusFourD <= pop ? head[XLEN-1:0] : '0;
          validD <= pop;
        end
      end
    end
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage for the pipelined MIPS CPU. It replaces the fixed single-register fetch with a latency-tolerant front end: it issues PC requests over a request/response instruction-memory handshake, buffers returned instructions in a QDEPTH-entry fetch queue, and feeds the IF/ID register (cmdD, PCPlusFourD) under decode stall and branch-redirect control. Stale responses still in flight after a redirect are counted and discarded.

## Interface
- XLEN, 32, data/address width
- QDEPTH, 4, fetch-queue entries; also the maximum number of in-flight imem requests (≥2, power of 2)
- RESET_PC, 32'h0000_0000, PC after reset

- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- stallD  in  1  hold the IF/ID register
- PCSrcD  in  1  branch taken in decode: redirect and flush
- PCBranchD  in  XLEN  redirect target
- imem_req  out  1  request valid
- imem_addr  out  XLEN  request address (fetch PC)
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  in-order response valid
- imem_rdata  in  XLEN  response instruction
- cmdD  out  XLEN  instruction to decode
- PCPlusFourD  out  XLEN  PC+4 of cmdD
- validD  out  1  cmdD is a real instruction (0 = bubble)

## Operation
- State: fetch PC `pc`, response PC `rpc`, queue occupancy `occ`, in-flight count `infl`, drop count `drop` (drop ≤ infl), IF/ID register.
- live = infl − drop. Issue condition: occ + live < QDEPTH and infl < QDEPTH and !PCSrcD and rst_n. imem_req = issue condition; imem_addr = pc.
- Accept (imem_req & imem_gnt): pc ← pc+4, infl+1.
- Response (imem_rvalid): infl−1. If drop>0: discard, drop−1. Else push {imem_rdata, rpc+4} to the queue and set rpc ← rpc+4. Queue never overflows by construction; a push while full is an assertion failure.
- Decode update, when !stallD and !PCSrcD: if occ>0, pop head into cmdD/PCPlusFourD, validD=1; else cmdD=0, PCPlusFourD=0, validD=0. stallD holds all three.
- Redirect (PCSrcD=1, priority over stallD): pc ← PCBranchD, rpc ← PCBranchD, queue cleared (occ=0), cmdD/PCPlusFourD/validD ← 0, no request issued, any same-cycle response discarded, drop ← infl − imem_rvalid (counting infl before the update).
- Queue push and pop in the same cycle are both performed; occ is unchanged. No bypass: a response reaches decode no earlier than the cycle after its push.
- All PC arithmetic is modulo 2^XLEN; wrap from 32'hFFFF_FFFC to 0 is legal.

## Timing
- Reset (rst_n=0 at an edge): pc=rpc=RESET_PC, occ=infl=drop=0, cmdD=0, PCPlusFourD=0, validD=0; imem_req=0 while rst_n=0. Reset mid-operation abandons in-flight requests; imem is reset on the same rst_n.
- Minimum latency with a zero-wait imem (gnt=1, rvalid the cycle after grant): request at edge n, push at n+1, cmdD valid after edge n+2.
- Steady state with a zero-wait imem: one instruction per cycle into decode.
- Redirect at edge r: first request to PCBranchD is issued in cycle r+1 (combinational imem_req after the edge); validD=0 for at least 3 edges after r with a zero-wait imem.

## Structure
- Package if_pkg: XLEN default, NOP_CMD = 0, fetch-entry struct {cmd, pc_plus4}, counter width function clog2(QDEPTH)+1.
- Sub-module sync_fifo (parametrised width/depth, push/pop/clear, occ output, registered read pointer) holds the queue; the parent holds the PC, counters and IF/ID register.

## Test plan
- Reset release, zero-wait imem returning 0x11,0x22,0x33… → after edge 2, cmdD=0x11, PCPlusFourD=4, then one instruction per cycle, PCPlusFourD stepping by 4.
- stallD high 3 cycles with imem ready → cmdD held, queue fills to QDEPTH=4, imem_req drops to 0; stall release → 4 queued instructions drain in order, no loss or duplicate.
- Responses delayed 2 cycles, PCSrcD with PCBranchD=0x100 while 2 requests are in flight → both stale responses discarded, next cmdD is from 0x100 with PCPlusFourD=0x104.
- PCSrcD and stallD asserted together → cmdD=0, validD=0 on that edge; fetch resumes at target.
- imem_gnt held low 5 cycles → imem_req and imem_addr stable, pc unchanged, validD=0 bubbles once the queue empties.
- rst_n low for one edge mid-stream → all outputs 0, next request address is RESET_PC; PC wrap: RESET_PC=32'hFFFF_FFF8 → addresses FFFF_FFF8, FFFF_FFFC, 0.
